// File: rtl/core101_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core101_arb_pkg
//  Description : Shared constants and helper functions for the arbitrated
//                N-input multiplexer (arb_mux_n) and its arbiter.
//                  DEFAULT_DATA_WIDTH / DEFAULT_NUM_SRC : parameter defaults
//                  MAX_SRC                              : largest NUM_SRC the
//                                                         helpers support
//                  rr_next(valid, last, n)              : round-robin winner
//                  onehot(idx)                          : index to one-hot
//  Revision    : 1.0 - initial release
// ============================================================================
package core101_arb_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_SRC    = 4;

    // The helpers work on fixed-width vectors so they can live in a package;
    // callers zero-extend their NUM_SRC-wide vectors into this width.
    localparam int MAX_SRC = 32;

    // Winner is the first valid index found searching last+1, last+2, ...
    // wrapping at n. Returns 0 when nothing is valid (caller gates with
    // any_valid). last and k are both below n, so one conditional subtract
    // replaces a modulo.
    function automatic int rr_next(input logic [MAX_SRC-1:0] valid,
                                   input int                 last,
                                   input int                 n);
        int   winner;
        int   idx;
        logic found;
        winner = 0;
        found  = 1'b0;
        for (int k = 1; k <= MAX_SRC; k++) begin
            if (k <= n && !found) begin
                idx = last + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (valid[idx]) begin
                    winner = idx;
                    found  = 1'b1;
                end
            end
        end
        return winner;
    endfunction

    function automatic logic [MAX_SRC-1:0] onehot(input int idx);
        logic [MAX_SRC-1:0] oh;
        oh = '0;
        if (idx >= 0 && idx < MAX_SRC) begin
            oh[idx] = 1'b1;
        end
        return oh;
    endfunction

endpackage : core101_arb_pkg
`default_nettype wire

// File: rtl/arb_mux_n_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter owning the last_grant pointer.
//                Winner is purely combinational from valid and last_grant;
//                the pointer moves to the winner only on an advance strobe.
//                Build macro ARB_MUX_FIXED_PRIO_EN selects fixed priority
//                (lowest valid index wins) and removes the pointer register.
//  Ports       : clk        in  clock, rising edge
//                rst        in  asynchronous active-high reset
//                valid      in  NUM_SRC request vector
//                advance    in  a transfer from the winner happens this cycle
//                winner     out SEL_WIDTH index of the selected source
//                any_valid  out at least one request is present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import core101_arb_pkg::*;
#(
    parameter int NUM_SRC   = DEFAULT_NUM_SRC,
    parameter int SEL_WIDTH = $clog2(NUM_SRC)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_SRC-1:0]   valid,
    input  logic                 advance,
    output logic [SEL_WIDTH-1:0] winner,
    output logic                 any_valid
);

    localparam logic [SEL_WIDTH-1:0] LAST_RESET = SEL_WIDTH'(NUM_SRC - 1);

    generate
        if (NUM_SRC < 2 || NUM_SRC > MAX_SRC) begin : g_bad_num_src
            $error("rr_arbiter: NUM_SRC must be in 2..MAX_SRC");
        end
    endgenerate

    logic [SEL_WIDTH-1:0] last_grant;

`ifdef ARB_MUX_FIXED_PRIO_EN
    // Pinning the pointer to the top index makes the search start at 0,
    // which is exactly fixed lowest-index-first priority.
    assign last_grant = LAST_RESET;
    logic unused_fixed;
    assign unused_fixed = &{1'b0, clk, rst, advance};
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= LAST_RESET;
        end else if (advance) begin
            last_grant <= winner;
        end
    end
`endif

    always_comb begin
        winner    = SEL_WIDTH'(rr_next(MAX_SRC'(valid), int'(last_grant), NUM_SRC));
        any_valid = |valid;
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/arb_mux_n.sv
`default_nettype none
// ============================================================================
//  Module      : arb_mux_n
//  Description : NUM_SRC-input arbitrated multiplexer with a registered
//                single-entry output stage (valid/ready on both sides).
//                Optional build macro ARB_MUX_FIXED_PRIO_EN switches the
//                arbiter from round-robin to fixed lowest-index priority.
//  Ports       : clock_in        in  clock, rising edge
//                reset_in        in  asynchronous active-high reset
//                src_valid_in    in  per-source request valid
//                src_data_in     in  packed source words, source i at
//                                    [i*DATA_WIDTH +: DATA_WIDTH]
//                src_ready_out   out per-source accept, at most one bit set
//                data_valid_out  out output register holds a word
//                data_out        out held word
//                grant_idx_out   out source index of the held word
//                data_ready_in   in  downstream accepts the held word
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_mux_n
    import core101_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_SRC    = DEFAULT_NUM_SRC,
    localparam int SEL_WIDTH = $clog2(NUM_SRC)
) (
    input  logic                          clock_in,
    input  logic                          reset_in,
    input  logic [NUM_SRC-1:0]            src_valid_in,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_in,
    output logic [NUM_SRC-1:0]            src_ready_out,
    output logic                          data_valid_out,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic [SEL_WIDTH-1:0]          grant_idx_out,
    input  logic                          data_ready_in
);

    logic [SEL_WIDTH-1:0] winner;
    logic                 any_valid;
    logic                 load_en;
    logic [MAX_SRC-1:0]   winner_onehot;

    rr_arbiter #(
        .NUM_SRC   (NUM_SRC),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_arbiter (
        .clk       (clock_in),
        .rst       (reset_in),
        .valid     (src_valid_in),
        .advance   (load_en),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // The output slot can take a word when empty or when its current word
    // leaves this cycle, giving one word per cycle. Accepts are suppressed
    // while reset is held so no source believes it transferred.
    always_comb begin
        load_en       = any_valid && (!data_valid_out || data_ready_in) && !reset_in;
        winner_onehot = onehot(int'(winner));
        src_ready_out = load_en ? winner_onehot[NUM_SRC-1:0] : '0;
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            data_valid_out <= 1'b0;
            data_out       <= '0;
            grant_idx_out  <= '0;
        end else if (load_en) begin
            data_valid_out <= 1'b1;
            data_out       <= src_data_in[winner*DATA_WIDTH +: DATA_WIDTH];
            grant_idx_out  <= winner;
        end else if (data_ready_in) begin
            // Word consumed with nothing to replace it; data/index keep
            // their stale values, which are don't-care while invalid.
            data_valid_out <= 1'b0;
        end
    end

endmodule : arb_mux_n
`default_nettype wire

// File: doc/arb_mux_n.md
Name: arb_mux_n

Overview:
- Parametrised N-input arbitrated multiplexer: the next generation of the core's 2-1 data select, for sharing one downstream port (e.g. memory/bus request path) among NUM_SRC producers.
- Round-robin arbitration over valid/ready sources.
- Registered single-entry output stage with valid/ready handshake.
- Reports the index of the source that produced the held word.

Parameters:
- DATA_WIDTH, 32, width of each source word and of data_out.
- NUM_SRC, 4, number of sources; must be ≥ 2 (elaboration-time error otherwise).
- SEL_WIDTH, $clog2(NUM_SRC), width of grant_idx_out; derived, not overridden.

Ports:
- clock_in  input  1  single clock, rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- src_valid_in  input  NUM_SRC  per-source request valid; bit i = source i.
- src_data_in  input  NUM_SRC*DATA_WIDTH  packed source words; source i at [i*DATA_WIDTH +: DATA_WIDTH].
- src_ready_out  output  NUM_SRC  per-source accept, at most one bit high.
- data_valid_out  output  1  output register holds a word.
- data_out  output  DATA_WIDTH  held word.
- grant_idx_out  output  SEL_WIDTH  source index of the held word.
- data_ready_in  input  1  downstream accepts the held word this cycle.

Behaviour:
- Reset (async assert, sync release): data_valid_out=0, data_out=0, grant_idx_out=0, round-robin pointer last_grant=NUM_SRC-1, so source 0 has first priority.
- load_en = any(src_valid_in) && (!data_valid_out || data_ready_in).
- Grant selection:
  - Winner w is the first i with src_valid_in[i], searching last_grant+1, last_grant+2, … modulo NUM_SRC.
  - Wrap from NUM_SRC-1 to 0.
  - Purely combinational from src_valid_in and last_grant.
- src_ready_out = one-hot(w) when load_en, else all zero.
- A transfer from source i occurs when src_valid_in[i] && src_ready_out[i].
- On load_en at rising edge:
  - data_out ← word w; grant_idx_out ← w; data_valid_out ← 1; last_grant ← w.
- Downstream transfer (data_valid_out && data_ready_in) with no load_en: data_valid_out ← 0. data_out and grant_idx_out keep their last value; they are don't-care when invalid.
- Stall (data_valid_out && !data_ready_in):
  - data_out and grant_idx_out stable.
  - src_ready_out all zero.
  - last_grant unchanged.
- Simultaneous downstream transfer and new load: both occur in the same cycle, giving full throughput of 1 word/cycle.
- Latency: source transfer at edge k → data_valid_out high after edge k.
- Combinational path data_ready_in → src_ready_out is intended; no path from src_data_in to any output except through the register.
- Sources may drop valid without transferring; arbitration is re-evaluated every cycle, with no grant lock.
- last_grant advances only on an actual source transfer, never on idle cycles.
- Fairness: with all sources continuously valid and the sink always ready, grant order is 0,1,…,NUM_SRC-1,0,…
- Reset mid-operation: a held word is discarded, with no handshake; all outputs return to reset values immediately.

Optional Feature:
- Macro ARB_MUX_FIXED_PRIO_EN.
- Defined:
  - Fixed priority; the lowest valid index always wins.
  - last_grant register is not instantiated.
  - All other behaviour identical.
- Undefined: round-robin as above.

Decomposition:
- Package core101_arb_pkg:
  - Default DATA_WIDTH/NUM_SRC constants.
  - Function rr_next(valid, last) returning the winner index.
  - Function onehot(idx) for src_ready_out generation.
- Sub-module rr_arbiter, which is natural:
  - Inputs: valid vector, advance strobe.
  - Outputs: winner index and any_valid.
  - Owns last_grant and the ARB_MUX_FIXED_PRIO_EN switch.
- arb_mux_n instantiates rr_arbiter, the data select and the output register.

Test Plan:
- Reset with src_valid_in=4'b1111 held → all outputs zero during reset; first edge after release loads source 0, grant_idx_out=0.
- All four valid, data_ready_in=1, src word i = 32'hA000_000i → data_out sequence A0000000, A0000001, A0000002, A0000003, A0000000; one word per cycle; src_ready_out one-hot matching.
- Sink stall: word 32'h1234_5678 from src 2 held, data_ready_in=0 for 5 cycles while src 0/1/3 valid → data_out/grant_idx_out stable, src_ready_out=0; on release, next grant = 3.
- Sparse requests: only src 1 valid, then only src 1 and src 0 valid → src 1, then src 0 (wrap past 3), then src 1.
- Async reset asserted mid-stall with data_valid_out=1 → data_valid_out=0 immediately without a clock; after release, first grant is source 0 again.
- Compile with ARB_MUX_FIXED_PRIO_EN, all valid, sink ready → data_out always source 0 (A0000000); src 2 granted only when src 0/1 invalid.
